// File: rtl/i2s_rx_master.sv
// I2S receive master: drives sck/ws, deserialises sd_i MSB first,
// and queues {channel, word} entries on a valid/ready stream.
module i2s_rx_master #(
  parameter int DATA_WIDTH = 24,
  parameter int CHNL_WIDTH = 32,
  parameter int DIV_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  output logic                  sck_o,
  output logic                  ws_o,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  chnl_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  localparam int SW = (CHNL_WIDTH > 1) ? $clog2(CHNL_WIDTH) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam logic [SW-1:0] S_LAST_BIT = SW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] S_LAST     = SW'(CHNL_WIDTH - 1);
  localparam logic [NW-1:0] FULL_CNT   = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;

  logic                  r_sck;
  logic                  r_ws;
  logic                  r_dummy;
  logic [DIV_WIDTH-1:0]  r_div_q;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [SW-1:0]         r_slot_cnt;
  logic [DATA_WIDTH-2:0] r_shift;

  logic                  w_tick;
  logic                  w_fall;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_word;

  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_chnl;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [NW-1:0]         r_count;
  logic                  r_ovf;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovf_set;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; dropping en_i returns to IDLE from anywhere
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    unique case (r_state)
      S_IDLE:  if (en_i) w_state_nxt = S_START;
      S_START: w_state_nxt = en_i ? S_RUN : S_IDLE;
      S_RUN: begin
        w_run = en_i;
        if (!en_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_tick = (r_div_cnt == r_div_q);
  assign w_fall = w_run & w_tick & r_sck;
  assign w_word = {r_shift, sd_i};
  assign w_push = w_fall & (r_slot_cnt == S_LAST_BIT) & ~r_dummy;

  // Bit clock divider and slot framing; cleared whenever not running
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      r_sck      <= 1'b0;
      r_ws       <= 1'b0;
      r_div_cnt  <= '0;
      r_slot_cnt <= '0;
      r_dummy    <= 1'b1;
    end else begin
      unique case (r_state)
        S_START: begin
          r_ws    <= 1'b1;
          r_dummy <= 1'b1;
        end
        S_RUN: begin
          if (w_tick) begin
            r_sck     <= ~r_sck;
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
          if (w_fall) begin
            if (r_slot_cnt == S_LAST) begin
              r_slot_cnt <= '0;
              r_ws       <= ~r_ws;
              r_dummy    <= 1'b0;
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_sck      <= 1'b0;
          r_ws       <= 1'b0;
          r_div_cnt  <= '0;
          r_slot_cnt <= '0;
          r_dummy    <= 1'b1;
        end
      endcase
    end
  end

  // Divider value is frozen for the whole run
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_div_q <= '0;
    else if (en_i && r_state == S_START)
      r_div_q <= clk_div_i;
  end

  // Shift in the data bits of each slot; later bits are ignored
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_shift <= '0;
    else if (w_fall && r_slot_cnt <= S_LAST_BIT)
      r_shift <= w_word[DATA_WIDTH-2:0];
  end

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = valid_o & ready_i;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem_data[i] <= '0;
      r_mem_chnl <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_wr) begin
        r_mem_data[r_wr_ptr] <= w_word;
        r_mem_chnl[r_wr_ptr] <= r_ws;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun; a new overrun beats a clear in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (ovf_clr_i) r_ovf <= 1'b0;
  end

  assign sck_o   = r_sck;
  assign ws_o    = r_ws;
  assign data_o  = r_mem_data[r_rd_ptr];
  assign chnl_o  = r_mem_chnl[r_rd_ptr];
  assign valid_o = (r_count != '0);
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: behavioural transmitter plus expected
// word stream, directed phases, two instances (32- and 24-bit slots).
module tb_i2s_rx_master;

  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i, en_i, sel, ready_i, ovf_clr_i;
  logic       sd_i = 1'b0;
  logic [7:0] clk_div_i;

  logic          a_sck, a_ws, a_chnl, a_valid, a_ovf;
  logic [DW-1:0] a_data;
  logic          b_sck, b_ws, b_chnl, b_valid, b_ovf;
  logic [DW-1:0] b_data;

  logic          w_sck, w_ws, w_chnl, w_valid, w_ovf;
  logic [DW-1:0] w_data;

  i2s_rx_master u_a (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i & ~sel),
    .clk_div_i(clk_div_i), .sck_o(a_sck), .ws_o(a_ws),
    .sd_i(sd_i), .data_o(a_data), .chnl_o(a_chnl),
    .valid_o(a_valid), .ready_i(ready_i), .ovf_o(a_ovf),
    .ovf_clr_i(ovf_clr_i)
  );

  i2s_rx_master #(.CHNL_WIDTH(24)) u_b (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i & sel),
    .clk_div_i(clk_div_i), .sck_o(b_sck), .ws_o(b_ws),
    .sd_i(sd_i), .data_o(b_data), .chnl_o(b_chnl),
    .valid_o(b_valid), .ready_i(ready_i), .ovf_o(b_ovf),
    .ovf_clr_i(ovf_clr_i)
  );

  assign w_sck   = sel ? b_sck   : a_sck;
  assign w_ws    = sel ? b_ws    : a_ws;
  assign w_chnl  = sel ? b_chnl  : a_chnl;
  assign w_valid = sel ? b_valid : a_valid;
  assign w_ovf   = sel ? b_ovf   : a_ovf;
  assign w_data  = sel ? b_data  : a_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] rx_q[$];

  int          fcnt = 0;
  int          rcnt = 0;
  bit          cur_dummy = 1'b1;
  bit          first_slot = 1'b1;
  bit          pat_mode = 1'b0;
  bit          p_sck = 1'b0;
  bit          p_ws = 1'b0;
  logic [DW-1:0] tx_word = '0;

  // Transmitter and expected stream: a word is expected once all DW
  // of its bits were clocked by enabled falling edges, except in the
  // first slot after a start.
  always @(posedge clk) begin
    #1;
    if (p_sck && !w_sck && en_i && !rst_i) begin
      fcnt++;
      if (fcnt == DW && !cur_dummy)
        exp_q.push_back({p_ws, tx_word});
    end
    if (w_ws != p_ws) begin
      fcnt = 0;
      rcnt = 0;
      cur_dummy = first_slot;
      first_slot = 1'b0;
      tx_word = pat_mode ? (w_ws ? 24'h0F1E2D : 24'hA5C3F0)
                         : 24'($urandom);
    end
    if (!p_sck && w_sck) begin
      sd_i = (rcnt < DW) ? tx_word[DW-1-rcnt] : 1'($urandom);
      rcnt++;
    end
    p_sck = w_sck;
    p_ws  = w_ws;
  end

  // Record every accepted stream beat
  always @(negedge clk) begin
    if (w_valid && ready_i) rx_q.push_back({w_chnl, w_data});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input bit use_ws);
    return use_ws ? w_ws : w_sck;
  endfunction

  // Clock cycles between two consecutive rising edges
  task automatic measure(input bit use_ws, output int per);
    logic p;
    bit   got;
    per = -1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      p = sig(use_ws);
      tick();
      if (!p && sig(use_ws)) got = 1'b1;
    end
    if (got) begin
      got = 1'b0;
      for (int i = 1; i <= 3000 && !got; i++) begin
        p = sig(use_ws);
        tick();
        if (!p && sig(use_ws)) begin
          got = 1'b1;
          per = i;
        end
      end
    end
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 20000 && exp_q.size() < n; i++) tick();
    check("wait_words", exp_q.size() >= n, 1);
  endtask

  task automatic stop_and_drain();
    en_i = 1'b0;
    ready_i = 1'b1;
    repeat (20) tick();
  endtask

  task automatic cmp_stream(input string tag, input int n);
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  int per;
  int base;
  bit found;

  initial begin
    rst_i = 1'b1; en_i = 1'b0; sel = 1'b0; ready_i = 1'b1;
    ovf_clr_i = 1'b0; clk_div_i = 8'd1;
    repeat (3) tick();
    check("rst_sck", w_sck, 0);
    check("rst_ws", w_ws, 0);
    check("rst_valid", w_valid, 0);
    check("rst_ovf", w_ovf, 0);
    check("rst_data", w_data, 0);
    check("rst_chnl", w_chnl, 0);
    rst_i = 1'b0;
    tick();

    // loopback with fixed pattern
    pat_mode = 1'b1; first_slot = 1'b1; en_i = 1'b1;
    measure(1'b0, per);
    check("t1_sck_period", per, 4);
    measure(1'b1, per);
    check("t1_ws_period", per, 256);
    wait_words(6);
    stop_and_drain();
    if (rx_q.size() >= 2) begin
      check("t1_first_left", rx_q[0], {1'b0, 24'hA5C3F0});
      check("t1_first_right", rx_q[1], {1'b1, 24'h0F1E2D});
    end
    cmp_stream("t1", exp_q.size());

    // divider latched at start, random data
    pat_mode = 1'b0; clk_div_i = 8'd3; first_slot = 1'b1; en_i = 1'b1;
    measure(1'b0, per);
    check("t2_sck_period", per, 8);
    clk_div_i = 8'd0;
    measure(1'b0, per);
    check("t2_sck_hold", per, 8);
    measure(1'b1, per);
    check("t2_ws_period", per, 512);
    en_i = 1'b0;
    repeat (3) tick();
    first_slot = 1'b1; en_i = 1'b1;
    measure(1'b0, per);
    check("t2_sck_new", per, 2);
    base = exp_q.size();
    wait_words(base + 4);
    stop_and_drain();
    cmp_stream("t2", exp_q.size());

    // overrun, set wins over clear, sticky, then clear
    ready_i = 1'b0; ovf_clr_i = 1'b1; first_slot = 1'b1; en_i = 1'b1;
    wait_words(5);
    check("t3_ovf_set_wins", w_ovf, 1);
    ovf_clr_i = 1'b0; en_i = 1'b0;
    tick();
    check("t3_ovf_sticky", w_ovf, 1);
    check("t3_valid", w_valid, 1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("t3_ovf_clr", w_ovf, 0);
    ready_i = 1'b1;
    repeat (20) tick();
    cmp_stream("t3", 4);

    // full FIFO with pop on the push cycle
    ready_i = 1'b0; first_slot = 1'b1; en_i = 1'b1;
    wait_words(4);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (fcnt == DW - 1 && !cur_dummy && w_sck) found = 1'b1;
      else tick();
    end
    check("t4_align", found, 1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("t4_ovf", w_ovf, 0);
    check("t4_pushed", exp_q.size(), 5);
    check("t4_one_pop", rx_q.size(), 1);
    check("t4_valid", w_valid, 1);
    stop_and_drain();
    cmp_stream("t4", 5);

    // disable mid left slot
    clk_div_i = 8'd1; ready_i = 1'b1; first_slot = 1'b1; en_i = 1'b1;
    wait_words(2);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (w_ws == 1'b0 && fcnt == 10 && !cur_dummy) found = 1'b1;
      else tick();
    end
    check("t5_align", found, 1);
    en_i = 1'b0;
    tick();
    check("t5_sck_idle", w_sck, 0);
    check("t5_ws_idle", w_ws, 0);
    repeat (300) tick();
    check("t5_no_push", rx_q.size(), 2);
    check("t5_valid", w_valid, 0);
    cmp_stream("t5a", 2);
    first_slot = 1'b1; en_i = 1'b1;
    wait_words(3);
    stop_and_drain();
    cmp_stream("t5b", exp_q.size());

    // reset mid slot with a loaded FIFO
    ready_i = 1'b0; first_slot = 1'b1; en_i = 1'b1;
    wait_words(2);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (fcnt == 10 && !cur_dummy) found = 1'b1;
      else tick();
    end
    check("t5_rst_align", found, 1);
    check("t5_pre_rst_valid", w_valid, 1);
    rst_i = 1'b1;
    tick();
    check("t5_rst_valid", w_valid, 0);
    check("t5_rst_sck", w_sck, 0);
    check("t5_rst_ws", w_ws, 0);
    check("t5_rst_data", w_data, 0);
    check("t5_rst_chnl", w_chnl, 0);
    en_i = 1'b0;
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("t5_post_rst_valid", w_valid, 0);
    rx_q.delete();
    exp_q.delete();

    // slot width equal to data width
    sel = 1'b1; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; clk_div_i = 8'd0; ready_i = 1'b1;
    first_slot = 1'b1; en_i = 1'b1;
    measure(1'b1, per);
    check("t6_ws_period", per, 96);
    wait_words(6);
    stop_and_drain();
    cmp_stream("t6", exp_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
